maindec_pipe: RTL and testbench
===============================

// Module: maindec_pipe
// PURPOSE
//  Registered main decoder for the ID stage. Maps a 32-bit MIPS instruction to
//  the 12-bit control bundle, flags reserved instructions, and interlocks HI/LO
//  users behind an in-flight multi-cycle MULT/DIV. Sits between IF/ID and ID/EX
//  with valid/ready handshakes on both sides.
// PARAMETERS
//  MUL_CYCLES  4   cycles HI/LO stays busy after a MULT/MULTU is accepted downstream (>=1)
//  DIV_CYCLES  32  cycles HI/LO stays busy after a DIV/DIVU is accepted downstream (>=1)
//  HILO_ILOCK  1   1: hold HI/LO users while busy; 0: no interlock, md_busy tied 0
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-high
//  in_valid   in   1   instr is valid
//  in_ready   out  1   decoder accepts instr this cycle
//  instr      in   32  instruction word
//  flush      in   1   synchronous kill of the output register
//  out_valid  out  1   ctrl/ri valid
//  out_ready  in   1   ID/EX accepts
//  ctrl       out  12  {memtoreg,memen,memwrite,branch,alusrc,regdst,regwrite,hilowrite,jump,jal,jr,bal}
//  ri         out  1   reserved-instruction flag (ctrl is all-zero when set)
//  md_busy    out  1   HI/LO result pending
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-high (rst).
//  Reset: out_valid=0, ctrl=0, ri=0, md_busy=0, counter=0.
//  Latency: 1 cycle; decode is combinational, captured on accept (in_valid&&in_ready).
//  in_ready = (!out_valid || out_ready) && !flush && !(md_busy && is_hilo(instr)).
//  is_hilo: funct MFHI 010000/MTHI 010001/MFLO 010010/MTLO 010011/MULT(U)/DIV(U) 0110xx.
//  Decode (set bits; others 0):
//   op 000000: ALU funct -> regdst,regwrite; MFHI/MFLO -> regdst,regwrite;
//    MTHI/MTLO/MULT/MULTU/DIV/DIVU -> hilowrite; JR 001000 -> jump,jr;
//    JALR 001001 -> jr,jal,regdst,regwrite; instr==0 (NOP) -> none, ri=0.
//   op 001000-001111 (ADDI..LUI) -> alusrc,regwrite.
//   op 100000/100001/100011/100100/100101 (LB/LH/LW/LBU/LHU) -> memtoreg,memen,alusrc,regwrite.
//   op 101000/101001/101011 (SB/SH/SW) -> memen,memwrite,alusrc.
//   op 000100-000111 (BEQ/BNE/BLEZ/BGTZ) -> branch.
//   op 000001, rt 00000/00001 -> branch; rt 10000/10001 -> branch,bal,regwrite.
//   op 000010 J -> jump; op 000011 JAL -> jump,jal,regwrite.
//   anything else (incl. unknown funct/rt) -> ctrl=0, ri=1.
//  Output register: on accept load ctrl/ri, out_valid=1; else if out_ready, out_valid=0.
//  flush: out_valid<=0 next edge, overrides a same-cycle accept (in_ready is 0).
//  HI/LO FSM (IDLE/BUSY): output handshake (out_valid&&out_ready&&!flush) of
//   MULT(U) loads counter=MUL_CYCLES, DIV(U) loads DIV_CYCLES -> BUSY.
//   BUSY: counter decrements each cycle; md_busy = (counter!=0); at 0 -> IDLE.
//   Handshake of a new MULT/DIV while BUSY cannot occur (held at input).
//  A flushed, unaccepted MULT/DIV never starts the counter; flush does not cancel
//   a running counter (op already issued). Mid-op reset clears everything.
//  Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)+1); no wrap (saturates at 0).
// STRUCTURE
//  Shared package mips_ctrl_pkg: opcode/funct/rt constants (EXE_*), CTRL_W=12,
//   ctrl bit-index constants, per-class ctrl patterns.
//  Sub-module maindec_comb: pure combinational instr -> {ctrl,ri,is_hilo,is_mul,is_div};
//   maindec_pipe holds output register, handshake and HI/LO FSM.
// TESTING
//  1 reset mid-stream, out_ready=1: ADDI 0x20010005 -> next cycle ctrl=12'b000010100000, ri=0.
//  2 LW 0x8C220004 then SW 0xAC220008 back-to-back -> 12'b110010100000, then 12'b011010000000.
//  3 out_ready=0 two cycles with ORI held -> out_valid=1, ctrl stable, in_ready=0; release -> drains.
//  4 DIV 0x0043001A accepted, then MFLO 0x00001012 offered -> in_ready=0 for 32 cycles
//    (md_busy=1), MFLO accepted the cycle md_busy falls; an ADDU in between passes freely.
//  5 BGEZAL (op 000001, rt 10001) -> 12'b000100100001; op 000001 rt 00101 -> ctrl=0, ri=1.
//  6 flush with unaccepted MULT in output -> out_valid=0, md_busy stays 0;
//    HILO_ILOCK=0 build: MFHI right after DIV accepted at once.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control-decode definitions.
//  - opcode / funct / rt field constants (EXE_*)
//  - control bundle width, bit indices and per-class control patterns
//  - HI/LO interlock FSM state type
package mips_ctrl_pkg;

    localparam int CTRL_W = 12;

    // Bit positions inside the control bundle
    // {memtoreg,memen,memwrite,branch,alusrc,regdst,regwrite,hilowrite,jump,jal,jr,bal}
    localparam int CB_MEMTOREG  = 11;
    localparam int CB_MEMEN     = 10;
    localparam int CB_MEMWRITE  = 9;
    localparam int CB_BRANCH    = 8;
    localparam int CB_ALUSRC    = 7;
    localparam int CB_REGDST    = 6;
    localparam int CB_REGWRITE  = 5;
    localparam int CB_HILOWRITE = 4;
    localparam int CB_JUMP      = 3;
    localparam int CB_JAL       = 2;
    localparam int CB_JR        = 1;
    localparam int CB_BAL       = 0;

    localparam logic [CTRL_W-1:0] C_MEMTOREG  = CTRL_W'(1) << CB_MEMTOREG;
    localparam logic [CTRL_W-1:0] C_MEMEN     = CTRL_W'(1) << CB_MEMEN;
    localparam logic [CTRL_W-1:0] C_MEMWRITE  = CTRL_W'(1) << CB_MEMWRITE;
    localparam logic [CTRL_W-1:0] C_BRANCH    = CTRL_W'(1) << CB_BRANCH;
    localparam logic [CTRL_W-1:0] C_ALUSRC    = CTRL_W'(1) << CB_ALUSRC;
    localparam logic [CTRL_W-1:0] C_REGDST    = CTRL_W'(1) << CB_REGDST;
    localparam logic [CTRL_W-1:0] C_REGWRITE  = CTRL_W'(1) << CB_REGWRITE;
    localparam logic [CTRL_W-1:0] C_HILOWRITE = CTRL_W'(1) << CB_HILOWRITE;
    localparam logic [CTRL_W-1:0] C_JUMP      = CTRL_W'(1) << CB_JUMP;
    localparam logic [CTRL_W-1:0] C_JAL       = CTRL_W'(1) << CB_JAL;
    localparam logic [CTRL_W-1:0] C_JR        = CTRL_W'(1) << CB_JR;
    localparam logic [CTRL_W-1:0] C_BAL       = CTRL_W'(1) << CB_BAL;

    // Per-class control patterns
    localparam logic [CTRL_W-1:0] CTRL_RTYPE = C_REGDST | C_REGWRITE;
    localparam logic [CTRL_W-1:0] CTRL_HILO  = C_HILOWRITE;
    localparam logic [CTRL_W-1:0] CTRL_JR    = C_JUMP | C_JR;
    localparam logic [CTRL_W-1:0] CTRL_JALR  = C_JR | C_JAL | C_REGDST | C_REGWRITE;
    localparam logic [CTRL_W-1:0] CTRL_IMM   = C_ALUSRC | C_REGWRITE;
    localparam logic [CTRL_W-1:0] CTRL_LOAD  = C_MEMTOREG | C_MEMEN | C_ALUSRC | C_REGWRITE;
    localparam logic [CTRL_W-1:0] CTRL_STORE = C_MEMEN | C_MEMWRITE | C_ALUSRC;
    localparam logic [CTRL_W-1:0] CTRL_BR    = C_BRANCH;
    localparam logic [CTRL_W-1:0] CTRL_BRAL  = C_BRANCH | C_BAL | C_REGWRITE;
    localparam logic [CTRL_W-1:0] CTRL_J     = C_JUMP;
    localparam logic [CTRL_W-1:0] CTRL_JAL   = C_JUMP | C_JAL | C_REGWRITE;

    // Opcodes
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_REGIMM  = 6'b000001;
    localparam logic [5:0] EXE_J       = 6'b000010;
    localparam logic [5:0] EXE_JAL     = 6'b000011;
    localparam logic [5:0] EXE_BEQ     = 6'b000100;
    localparam logic [5:0] EXE_BNE     = 6'b000101;
    localparam logic [5:0] EXE_BLEZ    = 6'b000110;
    localparam logic [5:0] EXE_BGTZ    = 6'b000111;
    localparam logic [5:0] EXE_ADDI    = 6'b001000;
    localparam logic [5:0] EXE_ADDIU   = 6'b001001;
    localparam logic [5:0] EXE_SLTI    = 6'b001010;
    localparam logic [5:0] EXE_SLTIU   = 6'b001011;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;
    localparam logic [5:0] EXE_LB      = 6'b100000;
    localparam logic [5:0] EXE_LH      = 6'b100001;
    localparam logic [5:0] EXE_LW      = 6'b100011;
    localparam logic [5:0] EXE_LBU     = 6'b100100;
    localparam logic [5:0] EXE_LHU     = 6'b100101;
    localparam logic [5:0] EXE_SB      = 6'b101000;
    localparam logic [5:0] EXE_SH      = 6'b101001;
    localparam logic [5:0] EXE_SW      = 6'b101011;

    // SPECIAL funct codes
    localparam logic [5:0] EXE_SLL     = 6'b000000;
    localparam logic [5:0] EXE_SRL     = 6'b000010;
    localparam logic [5:0] EXE_SRA     = 6'b000011;
    localparam logic [5:0] EXE_SLLV    = 6'b000100;
    localparam logic [5:0] EXE_SRLV    = 6'b000110;
    localparam logic [5:0] EXE_SRAV    = 6'b000111;
    localparam logic [5:0] EXE_JR      = 6'b001000;
    localparam logic [5:0] EXE_JALR    = 6'b001001;
    localparam logic [5:0] EXE_MFHI    = 6'b010000;
    localparam logic [5:0] EXE_MTHI    = 6'b010001;
    localparam logic [5:0] EXE_MFLO    = 6'b010010;
    localparam logic [5:0] EXE_MTLO    = 6'b010011;
    localparam logic [5:0] EXE_MULT    = 6'b011000;
    localparam logic [5:0] EXE_MULTU   = 6'b011001;
    localparam logic [5:0] EXE_DIV     = 6'b011010;
    localparam logic [5:0] EXE_DIVU    = 6'b011011;
    localparam logic [5:0] EXE_ADD     = 6'b100000;
    localparam logic [5:0] EXE_ADDU    = 6'b100001;
    localparam logic [5:0] EXE_SUB     = 6'b100010;
    localparam logic [5:0] EXE_SUBU    = 6'b100011;
    localparam logic [5:0] EXE_AND     = 6'b100100;
    localparam logic [5:0] EXE_OR      = 6'b100101;
    localparam logic [5:0] EXE_XOR     = 6'b100110;
    localparam logic [5:0] EXE_NOR     = 6'b100111;
    localparam logic [5:0] EXE_SLT     = 6'b101010;
    localparam logic [5:0] EXE_SLTU    = 6'b101011;

    // REGIMM rt codes
    localparam logic [4:0] EXE_BLTZ    = 5'b00000;
    localparam logic [4:0] EXE_BGEZ    = 5'b00001;
    localparam logic [4:0] EXE_BLTZAL  = 5'b10000;
    localparam logic [4:0] EXE_BGEZAL  = 5'b10001;

    typedef enum logic {
        HL_IDLE = 1'b0,
        HL_BUSY = 1'b1
    } hl_state_t;

endpackage

// File: rtl/maindec_comb.sv
// Purely combinational main decoder.
// Ports:
//  instr    in  32  instruction word
//  ctrl     out 12  control bundle (all-zero for reserved instructions)
//  ri       out 1   reserved-instruction flag
//  is_hilo  out 1   instruction reads or writes HI/LO
//  is_mul   out 1   MULT/MULTU
//  is_div   out 1   DIV/DIVU
module maindec_comb
    import mips_ctrl_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ri,
    output logic              is_hilo,
    output logic              is_mul,
    output logic              is_div
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];

    always_comb begin
        ctrl    = '0;
        ri      = 1'b0;
        is_hilo = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (op)
            EXE_SPECIAL: begin
                // The all-zero word is a NOP: no control, not reserved.
                if (instr != 32'd0) begin
                    case (funct)
                        EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLLV, EXE_SRLV, EXE_SRAV,
                        EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU,
                        EXE_AND, EXE_OR, EXE_XOR, EXE_NOR,
                        EXE_SLT, EXE_SLTU: ctrl = CTRL_RTYPE;
                        EXE_MFHI, EXE_MFLO: begin
                            ctrl    = CTRL_RTYPE;
                            is_hilo = 1'b1;
                        end
                        EXE_MTHI, EXE_MTLO: begin
                            ctrl    = CTRL_HILO;
                            is_hilo = 1'b1;
                        end
                        EXE_MULT, EXE_MULTU: begin
                            ctrl    = CTRL_HILO;
                            is_hilo = 1'b1;
                            is_mul  = 1'b1;
                        end
                        EXE_DIV, EXE_DIVU: begin
                            ctrl    = CTRL_HILO;
                            is_hilo = 1'b1;
                            is_div  = 1'b1;
                        end
                        EXE_JR:   ctrl = CTRL_JR;
                        EXE_JALR: ctrl = CTRL_JALR;
                        default:  ri   = 1'b1;
                    endcase
                end
            end
            EXE_REGIMM: begin
                case (rt)
                    EXE_BLTZ, EXE_BGEZ:     ctrl = CTRL_BR;
                    EXE_BLTZAL, EXE_BGEZAL: ctrl = CTRL_BRAL;
                    default:                ri   = 1'b1;
                endcase
            end
            EXE_J:   ctrl = CTRL_J;
            EXE_JAL: ctrl = CTRL_JAL;
            EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: ctrl = CTRL_BR;
            EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU,
            EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI: ctrl = CTRL_IMM;
            EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU: ctrl = CTRL_LOAD;
            EXE_SB, EXE_SH, EXE_SW: ctrl = CTRL_STORE;
            default: ri = 1'b1;
        endcase
    end

endmodule

// File: rtl/maindec_pipe.sv
// Registered ID-stage main decoder with valid/ready on both sides and a
// HI/LO interlock behind an issued multi-cycle MULT/DIV.
// Ports:
//  clk, rst              clock, asynchronous active-high reset
//  in_valid/in_ready     upstream handshake, instr is the payload
//  flush                 kills the output register on the next edge
//  out_valid/out_ready   downstream handshake, ctrl/ri are the payload
//  md_busy               HI/LO result still pending
module maindec_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int HILO_ILOCK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ri,
    output logic              md_busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_ri;
    logic              dec_hilo;
    logic              dec_mul;
    logic              dec_div;

    maindec_comb u_dec (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .ri      (dec_ri),
        .is_hilo (dec_hilo),
        .is_mul  (dec_mul),
        .is_div  (dec_div)
    );

    logic              out_valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic              ri_reg;
    logic              mul_reg;
    logic              div_reg;
    hl_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic accept;
    logic hshake;

    assign md_busy  = (HILO_ILOCK != 0) && (cnt_reg != '0);
    assign in_ready = (!out_valid_reg || out_ready) && !flush && !(md_busy && dec_hilo);
    assign accept   = in_valid && in_ready;
    // A flushed instruction never counts as issued downstream.
    assign hshake   = out_valid_reg && out_ready && !flush;

    assign out_valid = out_valid_reg;
    assign ctrl      = ctrl_reg;
    assign ri        = ri_reg;

    // Output register. in_ready is low under flush, so flush and accept
    // never coincide; flush is still tested first for clarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            ri_reg        <= 1'b0;
            mul_reg       <= 1'b0;
            div_reg       <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            ctrl_reg      <= dec_ctrl;
            ri_reg        <= dec_ri;
            mul_reg       <= dec_mul;
            div_reg       <= dec_div;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // HI/LO busy FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HL_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // HI/LO busy FSM: next state. An issued MULT/DIV (re)loads the counter;
    // with the interlock on this cannot happen while BUSY.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (hshake && mul_reg) begin
            state_next = HL_BUSY;
            cnt_next   = CNT_W'(MUL_CYCLES);
        end else if (hshake && div_reg) begin
            state_next = HL_BUSY;
            cnt_next   = CNT_W'(DIV_CYCLES);
        end else begin
            case (state_reg)
                HL_IDLE: cnt_next = '0;
                HL_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_next = HL_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = HL_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maindec_pipe.sv
// Directed testbench for maindec_pipe: default instance plus an instance
// built without the HI/LO interlock.
module tb_maindec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, ri, md_busy;
    logic [31:0] instr;
    logic [11:0] ctrl;

    logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, ri_b, md_busy_b;
    logic [31:0] instr_b;
    logic [11:0] ctrl_b;

    int total  = 0;
    int passes = 0;

    always #5 clk = ~clk;

    maindec_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ctrl(ctrl), .ri(ri), .md_busy(md_busy)
    );

    maindec_pipe #(.MUL_CYCLES(4), .DIV_CYCLES(32), .HILO_ILOCK(0)) u_dut_noilock (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .instr(instr_b), .flush(flush_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .ctrl(ctrl_b), .ri(ri_b), .md_busy(md_busy_b)
    );

    localparam logic [31:0] I_ADDI   = 32'h20010005;
    localparam logic [31:0] I_LW     = 32'h8C220004;
    localparam logic [31:0] I_SW     = 32'hAC220008;
    localparam logic [31:0] I_ORI    = 32'h34210001;
    localparam logic [31:0] I_DIV    = 32'h0043001A;
    localparam logic [31:0] I_MULT   = 32'h00430018;
    localparam logic [31:0] I_MFLO   = 32'h00001012;
    localparam logic [31:0] I_MFHI   = 32'h00001010;
    localparam logic [31:0] I_ADDU   = 32'h00430821;

    localparam logic [11:0] P_IMM   = 12'b000010100000;
    localparam logic [11:0] P_LOAD  = 12'b110010100000;
    localparam logic [11:0] P_STORE = 12'b011010000000;
    localparam logic [11:0] P_RTYPE = 12'b000001100000;
    localparam logic [11:0] P_HILO  = 12'b000000010000;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [11:0] exp_ctrl;
        logic        exp_ri;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vecs[0]  = '{"nop",    32'h00000000, 12'b000000000000, 1'b0};
        vecs[1]  = '{"jr",     32'h03E00008, 12'b000000001010, 1'b0};
        vecs[2]  = '{"jalr",   32'h0040F809, 12'b000001100110, 1'b0};
        vecs[3]  = '{"j",      32'h08000010, 12'b000000001000, 1'b0};
        vecs[4]  = '{"jal",    32'h0C000010, 12'b000000101100, 1'b0};
        vecs[5]  = '{"beq",    32'h10220003, 12'b000100000000, 1'b0};
        vecs[6]  = '{"bgezal", 32'h04510004, 12'b000100100001, 1'b0};
        vecs[7]  = '{"regimm_rsv", 32'h04450004, 12'b000000000000, 1'b1};
        vecs[8]  = '{"op_rsv", 32'hFC000000, 12'b000000000000, 1'b1};
        vecs[9]  = '{"syscall_rsv", 32'h0000000C, 12'b000000000000, 1'b1};
        vecs[10] = '{"sll",    32'h00010880, 12'b000001100000, 1'b0};
        vecs[11] = '{"lb",     32'h80220000, 12'b110010100000, 1'b0};
        vecs[12] = '{"sb",     32'hA0220000, 12'b011010000000, 1'b0};
        vecs[13] = '{"mthi",   32'h00400011, 12'b000000010000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
        in_valid_b = 1'b0; instr_b = '0; flush_b = 1'b0; out_ready_b = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        rst = 1'b0;

        // Start a MULT, then reset mid-op
        in_valid = 1'b1; instr = I_MULT;
        tick();
        in_valid = 1'b0;
        tick();
        check("mult_busy_before_rst", 32'(md_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_ctrl", 32'(ctrl), 32'd0);
        check("midrst_md_busy", 32'(md_busy), 32'd0);
        tick();
        rst = 1'b0;

        // ADDI, then LW/SW back-to-back
        in_valid = 1'b1; instr = I_ADDI;
        #1;
        check("addi_in_ready", 32'(in_ready), 32'd1);
        tick();
        $display("txn addi ctrl=%b ri=%b", ctrl, ri);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_ctrl", 32'(ctrl), 32'(P_IMM));
        check("addi_ri", 32'(ri), 32'd0);
        instr = I_LW;
        tick();
        $display("txn lw ctrl=%b", ctrl);
        check("lw_ctrl", 32'(ctrl), 32'(P_LOAD));
        instr = I_SW;
        tick();
        $display("txn sw ctrl=%b", ctrl);
        check("sw_ctrl", 32'(ctrl), 32'(P_STORE));
        check("sw_valid", 32'(out_valid), 32'd1);

        // Backpressure with ORI held in the output register
        instr = I_ORI;
        tick();
        out_ready = 1'b0;
        instr = I_LW;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ctrl", 32'(ctrl), 32'(P_IMM));
        end
        $display("txn ori held ctrl=%b", ctrl);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_drain_ctrl", 32'(ctrl), 32'(P_LOAD));
        in_valid = 1'b0;
        tick();
        check("bp_drain_empty", 32'(out_valid), 32'd0);

        // Decode table
        foreach (vecs[k]) begin
            in_valid = 1'b1; instr = vecs[k].ins;
            tick();
            $display("txn %s instr=%h ctrl=%b ri=%b", vecs[k].name, vecs[k].ins, ctrl, ri);
            check({vecs[k].name, "_ctrl"}, 32'(ctrl), 32'(vecs[k].exp_ctrl));
            check({vecs[k].name, "_ri"}, 32'(ri), 32'(vecs[k].exp_ri));
        end
        in_valid = 1'b0;
        tick();

        // DIV, ADDU passes, MFLO held for the whole divide
        in_valid = 1'b1; instr = I_DIV;
        tick();
        check("div_ctrl", 32'(ctrl), 32'(P_HILO));
        instr = I_ADDU;
        #1;
        check("addu_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("addu_ctrl", 32'(ctrl), 32'(P_RTYPE));
        check("div_md_busy", 32'(md_busy), 32'd1);
        instr = I_MFLO;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            tick();
        end
        $display("txn mflo stalled %0d cycles", n);
        check("div_stall_cycles", 32'(n), 32'd32);
        check("div_busy_fell", 32'(md_busy), 32'd0);
        tick();
        check("mflo_ctrl", 32'(ctrl), 32'(P_RTYPE));
        check("mflo_valid", 32'(out_valid), 32'd1);

        // MULT then MFHI: shorter stall
        instr = I_MULT;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; instr = I_MFHI;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            tick();
        end
        $display("txn mfhi stalled %0d cycles", n);
        check("mult_stall_cycles", 32'(n), 32'd4);
        tick();
        in_valid = 1'b0;
        tick();

        // Flush an unissued MULT in the output register
        out_ready = 1'b0;
        in_valid = 1'b1; instr = I_MULT;
        tick();
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; flush = 1'b1; instr = I_ADDI;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        $display("txn flush out_valid=%b md_busy=%b", out_valid, md_busy);
        check("flush_valid", 32'(out_valid), 32'd0);
        tick();
        check("flush_md_busy_a", 32'(md_busy), 32'd0);
        tick();
        check("flush_md_busy_b", 32'(md_busy), 32'd0);

        // No-interlock build: MFHI right behind DIV
        in_valid_b = 1'b1; instr_b = I_DIV;
        tick();
        instr_b = I_MFHI;
        #1;
        check("noilock_in_ready_a", 32'(in_ready_b), 32'd1);
        tick();
        check("noilock_mfhi_ctrl", 32'(ctrl_b), 32'(P_RTYPE));
        check("noilock_md_busy", 32'(md_busy_b), 32'd0);
        #1;
        check("noilock_in_ready_b", 32'(in_ready_b), 32'd1);
        $display("txn noilock mfhi ctrl=%b md_busy=%b", ctrl_b, md_busy_b);
        in_valid_b = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
